// File: rtl/wb_regfile_if.sv
// Bus between the MA/WB pipeline register / decode stage and the write-back register file.
// The master side drives the write-back fields and read indices; the slave side returns data.
interface wb_regfile_if #(
  parameter int XLEN = 32
);
  logic [2:0]      ctrSignalsIn;
  logic [XLEN-1:0] ResultIn;
  logic [XLEN-1:0] DataIn;
  logic [XLEN-1:0] Imm32In;
  logic [XLEN-1:0] AddrIn;
  logic [4:0]      rdIn;
  logic [4:0]      rs1In;
  logic [4:0]      rs2In;
  logic [XLEN-1:0] rs1DataOut;
  logic [XLEN-1:0] rs2DataOut;
  logic [XLEN-1:0] wbDataOut;
  logic            wbEnOut;
  logic [31:0]     retireCntOut;

  modport master (
    output ctrSignalsIn, ResultIn, DataIn, Imm32In, AddrIn, rdIn, rs1In, rs2In,
    input  rs1DataOut, rs2DataOut, wbDataOut, wbEnOut, retireCntOut
  );

  modport slave (
    input  ctrSignalsIn, ResultIn, DataIn, Imm32In, AddrIn, rdIn, rs1In, rs2In,
    output rs1DataOut, rs2DataOut, wbDataOut, wbEnOut, retireCntOut
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select, architectural register file with two bypassed async read ports,
// and a free-running count of committed register writes.
module wb_regfile #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic         clkIn,
  input  logic         resetIn,
  wb_regfile_if.slave  bus
);

  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    WB_RESULT = 2'b00,
    WB_DATA   = 2'b01,
    WB_IMM    = 2'b10,
    WB_ADDR   = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic    reg_write;
    wb_sel_e wb_sel;
  } ctr_t;

  ctr_t            ctr;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] wb_data;
  logic            wb_en;
  logic [31:0]     retire_cnt_q;

  assign ctr = ctr_t'(bus.ctrSignalsIn);

  // Indices beyond the implemented register count behave like x0.
  function automatic logic idx_ok(input logic [4:0] idx);
    return ({1'b0, idx} < 6'(NREGS));
  endfunction

  function automatic logic [XLEN-1:0] read_port(
    input logic [4:0]      rs,
    input logic [4:0]      rd,
    input logic            en,
    input logic [XLEN-1:0] bypass
  );
    if (rs == 5'd0 || !idx_ok(rs))
      return '0;
    else if (en && rs == rd)
      return bypass;
    else
      return regs[rs[IDXW-1:0]];
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wb_data = bus.ResultIn;
    case (ctr.wb_sel)
      WB_RESULT: wb_data = bus.ResultIn;
      WB_DATA:   wb_data = bus.DataIn;
      WB_IMM:    wb_data = bus.Imm32In;
      WB_ADDR:   wb_data = bus.AddrIn;
      default:   wb_data = bus.ResultIn;
    endcase
  end

  // Reset suppresses the write, the bypass and the count in the same cycle.
  assign wb_en = ctr.reg_write && (bus.rdIn != 5'd0) && idx_ok(bus.rdIn) && !resetIn;

  assign bus.wbDataOut    = wb_data;
  assign bus.wbEnOut      = wb_en;
  assign bus.rs1DataOut   = read_port(bus.rs1In, bus.rdIn, wb_en, wb_data);
  assign bus.rs2DataOut   = read_port(bus.rs2In, bus.rdIn, wb_en, wb_data);
  assign bus.retireCntOut = retire_cnt_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order. The register file is built from flops,
  // so it can be cleared by reset like any other state.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      retire_cnt_q <= '0;
    end else if (wb_en) begin
      regs[bus.rdIn[IDXW-1:0]] <= wb_data;
      retire_cnt_q             <= retire_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile: the stimulus process queues expected
// outputs from a behavioural model; a monitor pops and compares them every cycle.
module tb_wb_regfile;

  logic clk;
  logic rst;

  wb_regfile_if #(.XLEN(32)) bus ();

  wb_regfile #(.NREGS(32), .XLEN(32)) dut (
    .clkIn   (clk),
    .resetIn (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wb;
    logic        en;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] rs, input logic en,
                                           input logic [4:0] rd, input logic [31:0] wb);
    if (rs == 0) return 32'd0;
    if (en && rs == rd) return wb;
    return m_regs[rs];
  endfunction

  task automatic step(input logic r, input logic [2:0] ctr,
                      input logic [31:0] res, input logic [31:0] dat,
                      input logic [31:0] imm, input logic [31:0] adr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] src [4];
    exp_t        e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.ctrSignalsIn = ctr;
    bus.ResultIn     = res;
    bus.DataIn       = dat;
    bus.Imm32In      = imm;
    bus.AddrIn       = adr;
    bus.rdIn         = rd;
    bus.rs1In        = rs1;
    bus.rs2In        = rs2;
    src   = '{res, dat, imm, adr};
    e.wb  = src[ctr[1:0]];
    e.en  = ctr[2] && (rd != 0) && !r;
    e.rs1 = ref_read(rs1, e.en, rd, e.wb);
    e.rs2 = ref_read(rs2, e.en, rd, e.wb);
    e.cnt = m_cnt;
    sb.push_back(e);
    // Model state after the coming edge.
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (e.en) begin
      m_regs[rd] = e.wb;
      m_cnt      = m_cnt + 32'd1;
    end
  endtask

  task automatic bubble(input logic [4:0] rs1, input logic [4:0] rs2);
    step(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, rs1, rs2);
  endtask

  initial begin : monitor
    int   n;
    exp_t e;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rs1", n, bus.rs1DataOut, e.rs1);
        check("rs2", n, bus.rs2DataOut, e.rs2);
        check("wbData", n, bus.wbDataOut, e.wb);
        check("wbEn", n, {31'd0, bus.wbEnOut}, {31'd0, e.en});
        check("retireCnt", n, bus.retireCntOut, e.cnt);
        n++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    rst              = 1'b1;
    bus.ctrSignalsIn = 3'b000;
    bus.ResultIn     = 32'd0;
    bus.DataIn       = 32'd0;
    bus.Imm32In      = 32'd0;
    bus.AddrIn       = 32'd0;
    bus.rdIn         = 5'd0;
    bus.rs1In        = 5'd0;
    bus.rs2In        = 5'd0;
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
    repeat (2) @(posedge clk);

    // Reset clears a previously written register and the counter.
    step(1'b0, 3'b100, 32'h1234, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, 5'd0);
    bubble(5'd5, 5'd5);
    step(1'b1, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
    step(1'b1, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
    bubble(5'd5, 5'd0);

    // Write-back mux over all four selections into x3.
    for (int s = 0; s < 4; s++)
      step(1'b0, {1'b1, 2'(s)}, 32'h11, 32'h22, 32'h33, 32'h44, 5'd3, 5'd3, 5'd0);
    bubble(5'd3, 5'd3);

    // Same-cycle bypass to both ports, then the array value.
    step(1'b0, 3'b101, 32'd0, 32'hDEADBEEF, 32'd0, 32'd0, 5'd7, 5'd7, 5'd7);
    bubble(5'd7, 5'd7);

    // x0 writes are dropped and not counted.
    step(1'b0, 3'b100, 32'hFFFF, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    bubble(5'd0, 5'd3);

    // Reset colliding with a write.
    step(1'b0, 3'b100, 32'h77, 32'd0, 32'd0, 32'd0, 5'd9, 5'd0, 5'd0);
    step(1'b1, 3'b100, 32'd5, 32'd0, 32'd0, 32'd0, 5'd9, 5'd9, 5'd9);
    bubble(5'd9, 5'd9);

    // Counter wrap via backdoor preload.
    bubble(5'd0, 5'd0);
    @(negedge clk);
    #1;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    step(1'b0, 3'b110, 32'd0, 32'd0, 32'hABCD, 32'd0, 5'd1, 5'd1, 5'd0);
    bubble(5'd1, 5'd0);

    // Random traffic with frequent read/write index collisions.
    for (int k = 0; k < 400; k++) begin
      rd  = 5'($urandom);
      rs1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      rs2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      step(($urandom_range(0, 49) == 0), 3'($urandom), $urandom, $urandom, $urandom,
           $urandom, rd, rs1, rs2);
    end
    bubble(5'd0, 5'd0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
